// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scan codes, host commands and the host-transmit state encoding.
package ps2_pkg;

    localparam logic [7:0] SC_RELEASE   = 8'hF0;
    localparam logic [7:0] SC_EXTEND    = 8'hE0;
    localparam logic [7:0] SC_KEY_A     = 8'h1C;
    localparam logic [7:0] SC_KEY_SPACE = 8'h29;
    localparam logic [7:0] SC_KEY_ENTER = 8'h5A;
    localparam logic [7:0] SC_KEY_ESC   = 8'h76;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_state_t;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-FF synchronizer, 4-sample glitch filter and falling-edge strobe.
module ps2_line_filter (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic filt,
    output logic fall
);

    logic       sync1_r;
    logic       sync2_r;
    logic [3:0] hist_r;
    logic       filt_r;
    logic       fall_r;

    // Synchronize, keep a 4-deep sample history and move the level only on a unanimous history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            hist_r  <= 4'b1111;
            filt_r  <= 1'b1;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= line;
            sync2_r <= sync1_r;
            hist_r  <= {hist_r[2:0], sync2_r};
            if (hist_r == 4'b1111) begin
                filt_r <= 1'b1;
            end else if (hist_r == 4'b0000) begin
                filt_r <= 1'b0;
            end else begin
                filt_r <= filt_r;
            end
            fall_r <= filt_r & (hist_r == 4'b0000);
        end
    end

    assign filt = filt_r;
    assign fall = fall_r;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame shifted on device clock edges.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_filt_s;
    logic          clk_fall_s;
    logic          dsync1_r;
    logic          dsync2_r;

    ps2_state_t    state_r,   state_n;
    logic [7:0]    data_r,    data_n;
    logic          parity_r,  parity_n;
    logic [3:0]    bit_cnt_r, bit_cnt_n;
    logic [IW-1:0] inh_cnt_r, inh_cnt_n;
    logic [TW-1:0] to_cnt_r,  to_cnt_n;
    logic          clk_oe_r,  clk_oe_n;
    logic          data_oe_r, data_oe_n;
    logic          done_r,    done_n;
    logic          ack_err_r, ack_err_n;
    logic          timeout_r, timeout_n;
    logic          tx_ready_r;

    ps2_line_filter u_clk_filter (
        .clk  (clk),
        .rst  (rst),
        .line (ps2_clk),
        .filt (clk_filt_s),
        .fall (clk_fall_s)
    );

    // Data line only needs metastability protection; it is sampled at filtered clock edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsync1_r <= 1'b1;
            dsync2_r <= 1'b1;
        end else begin
            dsync1_r <= ps2_data;
            dsync2_r <= dsync1_r;
        end
    end

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_n   = state_r;
        data_n    = data_r;
        parity_n  = parity_r;
        bit_cnt_n = bit_cnt_r;
        inh_cnt_n = inh_cnt_r;
        to_cnt_n  = to_cnt_r;
        clk_oe_n  = clk_oe_r;
        data_oe_n = data_oe_r;
        done_n    = 1'b0;
        ack_err_n = 1'b0;
        timeout_n = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (tx_valid) begin
                    data_n    = tx_data;
                    parity_n  = odd_parity(tx_data);
                    bit_cnt_n = 4'd0;
                    inh_cnt_n = '0;
                    clk_oe_n  = 1'b1;
                    state_n   = ST_INHIBIT;
                end else begin
                    state_n   = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                clk_oe_n  = 1'b1;
                data_oe_n = 1'b0;
                if (inh_cnt_r == IW'(INHIBIT_CYCLES - 1)) begin
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b1;
                    to_cnt_n  = '0;
                    state_n   = ST_RTS;
                end else begin
                    inh_cnt_n = inh_cnt_r + IW'(1);
                end
            end
            ST_RTS, ST_SHIFT, ST_ACK: begin
                clk_oe_n = 1'b0;
                if (clk_fall_s) begin
                    to_cnt_n = '0;
                    case (state_r)
                        ST_RTS: begin
                            // First device edge: the device has latched the start bit.
                            data_oe_n = ~data_r[0];
                            bit_cnt_n = 4'd1;
                            state_n   = ST_SHIFT;
                        end
                        ST_SHIFT: begin
                            if (bit_cnt_r < 4'd8) begin
                                data_oe_n = ~data_r[bit_cnt_r[2:0]];
                                bit_cnt_n = bit_cnt_r + 4'd1;
                            end else if (bit_cnt_r == 4'd8) begin
                                data_oe_n = ~parity_r;
                                bit_cnt_n = 4'd9;
                            end else begin
                                data_oe_n = 1'b0;
                                state_n   = ST_ACK;
                            end
                        end
                        ST_ACK: begin
                            data_oe_n = 1'b0;
                            if (dsync2_r == 1'b0) begin
                                done_n = 1'b1;
                            end else begin
                                ack_err_n = 1'b1;
                            end
                            state_n = ST_WAIT_IDLE;
                        end
                        default: begin
                            data_oe_n = 1'b0;
                            state_n   = ST_IDLE;
                        end
                    endcase
                end else if (to_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_n = 1'b1;
                    data_oe_n = 1'b0;
                    state_n   = ST_IDLE;
                end else begin
                    to_cnt_n = to_cnt_r + TW'(1);
                end
            end
            ST_WAIT_IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (clk_filt_s && dsync2_r) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_WAIT_IDLE;
                end
            end
            default: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                state_n   = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            data_r     <= 8'h00;
            parity_r   <= 1'b0;
            bit_cnt_r  <= 4'd0;
            inh_cnt_r  <= '0;
            to_cnt_r   <= '0;
            clk_oe_r   <= 1'b0;
            data_oe_r  <= 1'b0;
            done_r     <= 1'b0;
            ack_err_r  <= 1'b0;
            timeout_r  <= 1'b0;
            tx_ready_r <= 1'b1;
        end else begin
            state_r    <= state_n;
            data_r     <= data_n;
            parity_r   <= parity_n;
            bit_cnt_r  <= bit_cnt_n;
            inh_cnt_r  <= inh_cnt_n;
            to_cnt_r   <= to_cnt_n;
            clk_oe_r   <= clk_oe_n;
            data_oe_r  <= data_oe_n;
            done_r     <= done_n;
            ack_err_r  <= ack_err_n;
            timeout_r  <= timeout_n;
            tx_ready_r <= (state_n == ST_IDLE);
        end
    end

    assign tx_ready    = tx_ready_r;
    assign ps2_clk_oe  = clk_oe_r;
    assign ps2_data_oe = data_oe_r;
    assign done        = done_r;
    assign ack_err     = ack_err_r;
    assign timeout     = timeout_r;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with an open-drain PS/2 device model and a bit/result scoreboard.
module tb_ps2_tx;
    import ps2_pkg::*;

    localparam int INH  = 50;
    localparam int TO   = 1500;
    localparam int HALF = 40;
    localparam logic [23:0] RES_DONE = 24'h010000;
    localparam logic [23:0] RES_ACK  = 24'h000100;
    localparam logic [23:0] RES_TO   = 24'h000001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk, ps2_data;

    int vectors = 0;
    int miscompares = 0;
    int n_done = 0, n_ack = 0, n_to = 0;
    int d0, a0, t0;
    logic        exp_bits[$];
    logic [23:0] exp_res[$];

    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .done(done), .ack_err(ack_err), .timeout(timeout)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) n_done <= n_done + 1;
        if (ack_err === 1'b1) n_ack <= n_ack + 1;
        if (timeout === 1'b1) n_to <= n_to + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a byte and push the expected line bits (start, LSB-first data, odd parity, stop).
    task automatic send(input logic [7:0] b, input logic [23:0] res);
        int w = 0;
        int ones = 0;
        while (tx_ready !== 1'b1 && w < 500) begin tick(); w++; end
        check("ready_before_send", tx_ready, 1'b1);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_bits.push_back(b[i]);
            if (b[i]) ones++;
        end
        exp_bits.push_back((ones % 2) == 0);
        exp_bits.push_back(1'b1);
        exp_res.push_back(res);
    endtask

    task automatic wait_rts();
        int n = 0;
        while (ps2_clk_oe === 1'b1 && n < INH + 20) begin n++; tick(); end
        check("inhibit_len", n, INH);
        check("rts_clk_oe", ps2_clk_oe, 1'b0);
        check("start_bit", ps2_data, exp_bits.pop_front());
    endtask

    // Device clocks 11 edges; samples each host bit on the rising edge; may glitch or stop early.
    task automatic device_frame(input logic ack_low, input int glitch_bit, input int stop_at);
        repeat (HALF) tick();
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) dev_data_low = ack_low;
            dev_clk_low = 1'b1;
            repeat (HALF) tick();
            if (i == stop_at) return;
            dev_clk_low = 1'b0;
            if (i <= 10) check($sformatf("bit%0d", i), ps2_data, exp_bits.pop_front());
            if (i == glitch_bit) begin
                repeat (10) tick();
                dev_clk_low = 1'b1;
                repeat (2) tick();
                dev_clk_low = 1'b0;
                repeat (HALF - 12) tick();
            end else begin
                repeat (HALF) tick();
            end
        end
        dev_data_low = 1'b0;
    endtask

    task automatic finish_frame(input int bd, input int ba, input int bt);
        int w = 0;
        repeat (2) tick();
        while (tx_ready !== 1'b1 && w < 400) begin tick(); w++; end
        check("frame_end_ready", tx_ready, 1'b1);
        check("frame_end_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("result", {8'(n_done - bd), 8'(n_ack - ba), 8'(n_to - bt)}, exp_res.pop_front());
    endtask

    initial begin
        int k;
        rst = 1'b1;
        repeat (5) tick();
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("rst_pulses", {done, ack_err, timeout}, 3'b000);
        rst = 1'b0;
        tick();
        check("rst_ready", tx_ready, 1'b1);

        // Normal frames acknowledged by the device.
        d0 = n_done; a0 = n_ack; t0 = n_to;
        send(CMD_SET_LEDS, RES_DONE); wait_rts(); device_frame(1'b1, 0, 0); finish_frame(d0, a0, t0);
        d0 = n_done; a0 = n_ack; t0 = n_to;
        send(8'h00, RES_DONE); wait_rts(); device_frame(1'b1, 0, 0); finish_frame(d0, a0, t0);
        d0 = n_done; a0 = n_ack; t0 = n_to;
        send(8'h01, RES_DONE); wait_rts(); device_frame(1'b1, 0, 0); finish_frame(d0, a0, t0);

        // Short low glitch on the clock line between edges must not advance the bit.
        d0 = n_done; a0 = n_ack; t0 = n_to;
        send(8'h5A, RES_DONE); wait_rts(); device_frame(1'b1, 3, 0); finish_frame(d0, a0, t0);

        // Device leaves data high on the ACK clock.
        d0 = n_done; a0 = n_ack; t0 = n_to;
        send(8'h81, RES_ACK); wait_rts(); device_frame(1'b0, 0, 0); finish_frame(d0, a0, t0);

        // Device never clocks: abort exactly TO cycles after request-to-send.
        d0 = n_done; a0 = n_ack; t0 = n_to;
        send(8'h3C, RES_TO); wait_rts();
        k = 0;
        while (timeout !== 1'b1 && k < TO + 50) begin tick(); k++; end
        check("timeout_latency", k, TO);
        check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("timeout_ready", tx_ready, 1'b1);
        exp_bits.delete();
        finish_frame(d0, a0, t0);

        // Reset in the middle of the frame, then a clean command.
        send(8'hAA, RES_DONE); wait_rts(); device_frame(1'b1, 0, 4);
        #3 rst = 1'b1;
        #1 check("midframe_rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("midframe_rst_pulses", {done, ack_err, timeout}, 3'b000);
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        exp_bits.delete();
        exp_res.delete();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("post_rst_ready", tx_ready, 1'b1);
        d0 = n_done; a0 = n_ack; t0 = n_to;
        send(CMD_RESET, RES_DONE); wait_rts(); device_frame(1'b1, 0, 0); finish_frame(d0, a0, t0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
